// File: rtl/health_bar_ctl.sv
// Health bar overlay generator.
// Draws one bordered bar at a fixed screen position. The fill snaps to the
// new HP at once. A yellow "ghost" segment shows the HP just lost: it holds
// for a number of frames and then drains one step per frame. Bar widths are
// latched only on the frame tick, so a frame is never drawn with two widths.
// The pixel outputs are registered and lag hcount_in/vcount_in by one clock.
module health_bar_ctl #(
  parameter int BAR_X       = 32,
  parameter int BAR_Y       = 16,
  parameter int BAR_H       = 16,
  parameter int BORDER      = 2,
  parameter int HP_MAX      = 100,
  parameter int PX_PER_HP   = 2,
  parameter int HOLD_FRAMES = 30,
  parameter int STEP        = 1,
  parameter int LOW_THRESH  = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        vblnk_in,
  input  logic [7:0]  hp_in,
  input  logic        hp_valid,
  output logic        bar_on,
  output logic [11:0] rgb_bar,
  output logic [7:0]  hp_displayed,
  output logic        anim_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  // Geometry of the outer rectangle and of the interior inside the border.
  localparam int          OUT_W    = 2*BORDER + HP_MAX*PX_PER_HP;
  localparam logic [10:0] X_LO     = 11'(BAR_X);
  localparam logic [10:0] X_HI     = 11'(BAR_X + OUT_W - 1);
  localparam logic [10:0] Y_LO     = 11'(BAR_Y);
  localparam logic [10:0] Y_HI     = 11'(BAR_Y + BAR_H - 1);
  localparam logic [10:0] IX_LO    = 11'(BAR_X + BORDER);
  localparam logic [10:0] IX_HI    = 11'(BAR_X + OUT_W - 1 - BORDER);
  localparam logic [10:0] IY_LO    = 11'(BAR_Y + BORDER);
  localparam logic [10:0] IY_HI    = 11'(BAR_Y + BAR_H - 1 - BORDER);
  localparam logic [10:0] PX_V     = 11'(PX_PER_HP);
  localparam logic [10:0] FULL_W   = 11'(HP_MAX * PX_PER_HP);
  localparam logic [7:0]  HP_MAX_V = 8'(HP_MAX);
  localparam logic [7:0]  HOLD_V   = 8'(HOLD_FRAMES);
  localparam logic [7:0]  STEP_V   = 8'(STEP);
  localparam logic [7:0]  LOW_V    = 8'(LOW_THRESH);

  localparam logic [11:0] C_BORDER = 12'hFFF;
  localparam logic [11:0] C_FILL   = 12'h0F0;
  localparam logic [11:0] C_LOW_HI = 12'hF00;
  localparam logic [11:0] C_LOW_LO = 12'h800;
  localparam logic [11:0] C_GHOST  = 12'hFF0;
  localparam logic [11:0] C_EMPTY  = 12'h222;

  state_t      state_q, state_d;
  logic        vblnk_q;
  logic [7:0]  target_q;
  logic [7:0]  disp_q, disp_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  frame_q;
  logic [10:0] fill_w_q, ghost_w_q;
  logic        bar_on_q, bar_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        busy_q;

  logic        tick;
  logic [7:0]  hp_clamped;
  logic [7:0]  target_cur;
  logic        in_outer, in_inner;
  logic [10:0] ix;

  // A new HP value is visible in the same cycle as its strobe, so a strobe
  // that lands on the frame tick is already seen by that tick.
  assign tick       = vblnk_in & ~vblnk_q;
  assign hp_clamped = (hp_in > HP_MAX_V) ? HP_MAX_V : hp_in;
  assign target_cur = hp_valid ? hp_clamped : target_q;

  // Animation next-state: heal is instant, damage goes HOLD then DRAIN.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    hold_d  = hold_q;
    if (tick) begin
      if (target_cur >= disp_q) begin
        disp_d  = target_cur;
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_HOLD;
            hold_d  = HOLD_V;
          end
          ST_HOLD: begin
            if (hold_q == 8'd0) state_d = ST_DRAIN;
            else                hold_d  = hold_q - 8'd1;
          end
          ST_DRAIN: begin
            // disp_q > target_cur here, so the subtraction cannot wrap.
            if (disp_q - target_cur > STEP_V) disp_d = disp_q - STEP_V;
            else                              disp_d = target_cur;
            if (disp_d == target_cur) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    // Further damage while holding restarts the hold period.
    if (hp_valid && (hp_clamped < target_q) &&
        (state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
      hold_d = HOLD_V;
    end
  end

  // Pixel classification for the current hcount/vcount, in priority order.
  always_comb begin
    in_outer = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
               (vcount_in >= Y_LO) && (vcount_in <= Y_HI);
    in_inner = (hcount_in >= IX_LO) && (hcount_in <= IX_HI) &&
               (vcount_in >= IY_LO) && (vcount_in <= IY_HI);
    ix       = hcount_in - IX_LO;
    bar_on_d = 1'b0;
    rgb_d    = 12'h000;
    if (in_outer) begin
      bar_on_d = 1'b1;
      if (!in_inner)              rgb_d = C_BORDER;
      else if (ix < fill_w_q) begin
        if (target_cur > LOW_V)   rgb_d = C_FILL;
        else                      rgb_d = frame_q[4] ? C_LOW_LO : C_LOW_HI;
      end
      else if (ix < ghost_w_q)    rgb_d = C_GHOST;
      else                        rgb_d = C_EMPTY;
    end
  end

  // State, widths, frame counter and registered pixel outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vblnk_q   <= 1'b0;
      target_q  <= HP_MAX_V;
      disp_q    <= HP_MAX_V;
      hold_q    <= 8'd0;
      frame_q   <= 8'd0;
      fill_w_q  <= FULL_W;
      ghost_w_q <= FULL_W;
      bar_on_q  <= 1'b0;
      rgb_q     <= 12'h000;
      busy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vblnk_q  <= vblnk_in;
      disp_q   <= disp_d;
      hold_q   <= hold_d;
      busy_q   <= (state_d != ST_IDLE);
      bar_on_q <= bar_on_d;
      rgb_q    <= rgb_d;
      if (hp_valid) target_q <= hp_clamped;
      if (tick) begin
        frame_q   <= frame_q + 8'd1;
        fill_w_q  <= 11'(target_cur) * PX_V;
        ghost_w_q <= 11'(disp_d) * PX_V;
      end
    end
  end

  assign bar_on       = bar_on_q;
  assign rgb_bar      = rgb_q;
  assign hp_displayed = disp_q;
  assign anim_busy    = busy_q;

endmodule
